muldiv_sequencer: RTL and testbench

Multi-cycle unsigned multiply/divide controller for the EX stage of the 5-stage pipeline. It accepts a mul or div request from the ID/EX buffer and runs a radix-2 shift-add multiply or restoring divide, one iteration per clock. It drives a stall request toward the PC, IF/ID and hazard logic until the result is ready. The result is returned as a lo/hi pair: product, or quotient and remainder.

---
 rtl/muldiv_sequencer.sv | 161 ++++++++++++++++
 tb/tb_muldiv_sequencer.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/muldiv_sequencer.sv
// Multi-cycle unsigned multiply/divide sequencer for the EX stage.
// Radix-2 shift-add multiply and restoring divide, one bit per clock.
module muldiv_sequencer #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             op,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic             flush,
    output logic             busy,
    output logic             stall,
    output logic             done,
    output logic [WIDTH-1:0] result_lo,
    output logic [WIDTH-1:0] result_hi,
    output logic             div_by_zero
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [CW-1:0]    r_cnt;
    logic             r_op;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] r_lo;
    logic             r_busy;
    logic             r_dbz;
    logic [WIDTH-1:0] r_res_lo;
    logic [WIDTH-1:0] r_res_hi;

    logic             w_go;
    logic             w_dbz_req;
    logic             w_last;
    logic             w_stall;
    logic [WIDTH:0]   w_sum;
    logic [WIDTH-1:0] w_mhi;
    logic [WIDTH-1:0] w_mlo;
    logic [WIDTH:0]   w_shf;
    logic [WIDTH-1:0] w_diff;
    logic             w_ge;
    logic [WIDTH-1:0] w_dhi;
    logic [WIDTH-1:0] w_dlo;
    logic [WIDTH-1:0] w_hi_nxt;
    logic [WIDTH-1:0] w_lo_nxt;

    assign w_go      = (r_state == S_IDLE) && start && !flush;
    assign w_dbz_req = op && (op_b == '0);
    assign w_last    = (r_cnt == CW'(1));

    // Multiply: {hi,lo} holds partial product and remaining multiplier bits.
    assign w_sum = {1'b0, r_hi} + {1'b0, r_a};
    assign w_mhi = r_lo[0] ? w_sum[WIDTH:1]
                           : {1'b0, r_hi[WIDTH-1:1]};
    assign w_mlo = {(r_lo[0] ? w_sum[0] : r_hi[0]),
                    r_lo[WIDTH-1:1]};

    // Divide: hi is the partial remainder, lo shifts dividend out, quotient in.
    assign w_shf  = {r_hi, r_lo[WIDTH-1]};
    assign w_ge   = (w_shf >= {1'b0, r_a});
    assign w_diff = w_shf[WIDTH-1:0] - r_a;
    assign w_dhi  = w_ge ? w_diff : w_shf[WIDTH-1:0];
    assign w_dlo  = {r_lo[WIDTH-2:0], w_ge};

    assign w_hi_nxt = r_op ? w_dhi : w_mhi;
    assign w_lo_nxt = r_op ? w_dlo : w_mlo;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_stall     = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (start && !flush) begin
                    w_stall     = 1'b1;
                    w_state_nxt = w_dbz_req ? S_DONE : S_RUN;
                end
            end
            S_RUN: begin
                w_stall = 1'b1;
                if (flush) begin
                    w_state_nxt = S_IDLE;
                end else if (w_last) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt    <= '0;
            r_op     <= 1'b0;
            r_a      <= '0;
            r_hi     <= '0;
            r_lo     <= '0;
            r_busy   <= 1'b0;
            r_dbz    <= 1'b0;
            r_res_lo <= '0;
            r_res_hi <= '0;
        end else begin
            r_busy <= (w_state_nxt == S_RUN);
            if (w_go) begin
                r_op <= op;
                if (w_dbz_req) begin
                    r_res_lo <= '1;
                    r_res_hi <= op_a;
                    r_dbz    <= 1'b1;
                end else begin
                    r_a   <= op ? op_b : op_a;
                    r_lo  <= op ? op_a : op_b;
                    r_hi  <= '0;
                    r_cnt <= CW'(WIDTH);
                end
            end else if (r_state == S_RUN) begin
                if (flush) begin
                    r_cnt <= '0;
                end else begin
                    r_hi  <= w_hi_nxt;
                    r_lo  <= w_lo_nxt;
                    r_cnt <= r_cnt - CW'(1);
                    if (w_last) begin
                        r_res_hi <= w_hi_nxt;
                        r_res_lo <= w_lo_nxt;
                        r_dbz    <= 1'b0;
                    end
                end
            end
        end
    end

    assign busy        = r_busy;
    assign stall       = w_stall;
    assign done        = (r_state == S_DONE);
    assign result_lo   = r_res_lo;
    assign result_hi   = r_res_hi;
    assign div_by_zero = r_dbz;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Directed bench for muldiv_sequencer.
// Inputs change 1ns after posedge; outputs sampled at negedge.
module tb_muldiv_sequencer;

    localparam int W = 16;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic         op;
    logic [W-1:0] op_a;
    logic [W-1:0] op_b;
    logic         flush;
    logic         busy;
    logic         stall;
    logic         done;
    logic [W-1:0] result_lo;
    logic [W-1:0] result_hi;
    logic         div_by_zero;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    muldiv_sequencer #(.WIDTH(W)) u_dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .op         (op),
        .op_a       (op_a),
        .op_b       (op_b),
        .flush      (flush),
        .busy       (busy),
        .stall      (stall),
        .done       (done),
        .result_lo  (result_lo),
        .result_hi  (result_hi),
        .div_by_zero(div_by_zero)
    );

    task automatic chk(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h",
                     tag, got, exp);
        end
    endtask

    // Start at cycle 0, wait for done, check latency and results.
    task automatic run_op(input string tag,
                          input logic o,
                          input logic [W-1:0] a,
                          input logic [W-1:0] b,
                          input int exp_lat,
                          input logic [W-1:0] e_lo,
                          input logic [W-1:0] e_hi,
                          input logic e_dbz);
        int lat;
        int bad_stall;
        int bad_busy;
        lat       = -1;
        bad_stall = 0;
        bad_busy  = 0;
        @(posedge clk); #1;
        start = 1'b1;
        op    = o;
        op_a  = a;
        op_b  = b;
        @(negedge clk);
        chk({tag, ".stall0"}, 32'(stall), 32'd1);
        @(posedge clk); #1;
        start = 1'b0;
        for (int c = 1; c < 40; c++) begin
            @(negedge clk);
            if (done) begin
                lat = c;
                break;
            end
            if (stall !== 1'b1) bad_stall++;
            if (busy !== 1'b1) bad_busy++;
        end
        chk({tag, ".lat"}, 32'(lat), 32'(exp_lat));
        chk({tag, ".lo"}, 32'(result_lo), 32'(e_lo));
        chk({tag, ".hi"}, 32'(result_hi), 32'(e_hi));
        chk({tag, ".dbz"}, 32'(div_by_zero), 32'(e_dbz));
        chk({tag, ".stall_done"}, 32'(stall), 32'd0);
        chk({tag, ".busy_done"}, 32'(busy), 32'd0);
        if (exp_lat > 1) begin
            chk({tag, ".run_stall"}, 32'(bad_stall), 32'd0);
            chk({tag, ".run_busy"}, 32'(bad_busy), 32'd0);
        end
        @(negedge clk);
        chk({tag, ".done_1cyc"}, 32'(done), 32'd0);
    endtask

    initial begin
        int seen;
        rst   = 1'b1;
        start = 1'b0;
        op    = 1'b0;
        op_a  = '0;
        op_b  = '0;
        flush = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst.busy", 32'(busy), 32'd0);
        chk("rst.stall", 32'(stall), 32'd0);
        chk("rst.done", 32'(done), 32'd0);
        chk("rst.dbz", 32'(div_by_zero), 32'd0);
        chk("rst.lo", 32'(result_lo), 32'd0);
        chk("rst.hi", 32'(result_hi), 32'd0);

        run_op("mul300x200", 1'b0, 16'd300, 16'd200,
               17, 16'hEA60, 16'h0000, 1'b0);
        run_op("mulmax", 1'b0, 16'hFFFF, 16'hFFFF,
               17, 16'h0001, 16'hFFFE, 1'b0);
        run_op("div1000_7", 1'b1, 16'd1000, 16'd7,
               17, 16'h008E, 16'd6, 1'b0);
        run_op("div5_9", 1'b1, 16'd5, 16'd9,
               17, 16'd0, 16'd5, 1'b0);
        run_op("div0", 1'b1, 16'h1234, 16'h0000,
               1, 16'hFFFF, 16'h1234, 1'b1);
        run_op("mul3x5", 1'b0, 16'd3, 16'd5,
               17, 16'd15, 16'd0, 1'b0);

        // start with flush in IDLE: nothing begins
        @(posedge clk); #1;
        start = 1'b1; op = 1'b0; op_a = 16'd9; op_b = 16'd9;
        flush = 1'b1;
        @(negedge clk);
        chk("sf.stall", 32'(stall), 32'd0);
        @(posedge clk); #1;
        start = 1'b0; flush = 1'b0;
        @(negedge clk);
        chk("sf.busy", 32'(busy), 32'd0);
        chk("sf.done", 32'(done), 32'd0);

        // flush mid-multiply, with an ignored start at cycle 3
        @(posedge clk); #1;
        start = 1'b1; op = 1'b0; op_a = 16'd300; op_b = 16'd200;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        start = 1'b1; op = 1'b1; op_a = 16'h5555; op_b = 16'h0000;
        @(negedge clk);
        chk("fl.busy3", 32'(busy), 32'd1);
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        flush = 1'b1;
        @(negedge clk);
        chk("fl.stall5", 32'(stall), 32'd1);
        @(posedge clk); #1;
        flush = 1'b0;
        @(negedge clk);
        chk("fl.busy6", 32'(busy), 32'd0);
        chk("fl.stall6", 32'(stall), 32'd0);
        seen = 0;
        for (int c = 0; c < 25; c++) begin
            if (done) seen++;
            @(negedge clk);
        end
        chk("fl.nodone", 32'(seen), 32'd0);
        chk("fl.lo", 32'(result_lo), 32'd15);
        chk("fl.hi", 32'(result_hi), 32'd0);
        chk("fl.dbz", 32'(div_by_zero), 32'd0);

        // reset at cycle 8 of a divide
        @(posedge clk); #1;
        start = 1'b1; op = 1'b1; op_a = 16'd1000; op_b = 16'd7;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (7) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rs.busy", 32'(busy), 32'd0);
        chk("rs.stall", 32'(stall), 32'd0);
        chk("rs.done", 32'(done), 32'd0);
        chk("rs.lo", 32'(result_lo), 32'd0);
        chk("rs.hi", 32'(result_hi), 32'd0);
        chk("rs.dbz", 32'(div_by_zero), 32'd0);
        run_op("div_after_rst", 1'b1, 16'd1000, 16'd7,
               17, 16'h008E, 16'd6, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
